// File: rtl/gate_seq_pkg.sv
// +----------------------------------------------------------------------+
// | gate_seq_pkg: shared types and truth-table constants for the gate    |
// | vector sequencer and its expectation ROM.                            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package gate_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  localparam int Y_AND  = 0;
  localparam int Y_OR   = 1;
  localparam int Y_NAND = 2;
  localparam int Y_NOR  = 3;
  localparam int Y_XOR  = 4;
  localparam int Y_XNOR = 5;
  localparam int Y_NOT  = 6;

  // Builds one truth-table row so the bit layout lives in a single place.
  function automatic logic [6:0] gate_truth(input logic a, input logic b);
    logic [6:0] v;
    v          = '0;
    v[Y_AND]   = a & b;
    v[Y_OR]    = a | b;
    v[Y_NAND]  = ~(a & b);
    v[Y_NOR]   = ~(a | b);
    v[Y_XOR]   = a ^ b;
    v[Y_XNOR]  = ~(a ^ b);
    v[Y_NOT]   = ~a;
    return v;
  endfunction

  // Indexed by {a,b}: 00->6C, 01->56, 10->16, 11->23.
  localparam logic [3:0][6:0] EXP_TT = {
    gate_truth(1'b1, 1'b1),
    gate_truth(1'b1, 1'b0),
    gate_truth(1'b0, 1'b1),
    gate_truth(1'b0, 1'b0)
  };

endpackage

`default_nettype wire

// File: rtl/gate_expect_rom.sv
// +----------------------------------------------------------------------+
// | gate_expect_rom: combinational {a,b} index to expected gate response.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gate_expect_rom
  import gate_seq_pkg::*;
(
  input  logic [1:0] idx,
  output logic [6:0] expected
);

  assign expected = EXP_TT[idx];

endmodule

`default_nettype wire

// File: rtl/gate_vector_sequencer.sv
// +----------------------------------------------------------------------+
// | gate_vector_sequencer: sweeps {a,b} over the gate bank, checks the   |
// | response against the truth table and reports pass / error count.    |
// | Optional first-mismatch capture: GATE_SEQ_FIRST_FAIL_EN.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [6:0]           dut_y,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef GATE_SEQ_FIRST_FAIL_EN
  ,
  output logic [1:0]           first_fail_ab,
  output logic [6:0]           first_fail_vec,
  output logic                 first_fail_vld
`endif
);

  localparam int c_SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int c_PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [c_SC_W-1:0]    c_SETTLE_LOAD = c_SC_W'(SETTLE_CYCLES - 1);
  localparam logic [c_PC_W-1:0]    c_PASS_LAST   = c_PC_W'(NUM_PASSES - 1);
  localparam logic [ERR_CNT_W-1:0] c_ERR_MAX     = {ERR_CNT_W{1'b1}};

  seq_state_t            r_state;
  seq_state_t            w_next;
  logic [1:0]            r_idx;
  logic [c_PC_W-1:0]     r_pass_cnt;
  logic [c_SC_W-1:0]     r_settle;
  logic                  r_a;
  logic                  r_b;
  logic                  r_done;
  logic                  r_pass;
  logic [ERR_CNT_W-1:0]  r_err;
  logic [6:0]            w_exp;
  logic                  w_busy;
  logic                  w_launch;
  logic                  w_mismatch;
  logic                  w_last_vec;
  logic                  w_last_pass;
  logic                  w_settle_end;

`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic [1:0]            r_ff_ab;
  logic [6:0]            r_ff_vec;
  logic                  r_ff_vld;
`endif

  gate_expect_rom u_rom (
    .idx      (r_idx),
    .expected (w_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DRIVE;
      DRIVE:   w_next = SETTLE;
      SETTLE:  if (w_settle_end) w_next = CHECK;
      CHECK:   w_next = (w_last_vec && w_last_pass) ? DONE : DRIVE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // dut_y only matters through w_mismatch, which is gated to CHECK.
  always_comb begin
    w_busy       = (r_state != IDLE);
    w_launch     = (r_state == IDLE) && start;
    w_mismatch   = (r_state == CHECK) && (dut_y != w_exp);
    w_last_vec   = (r_idx == 2'd3);
    w_last_pass  = (r_pass_cnt == c_PASS_LAST);
    w_settle_end = (r_settle == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_idx      <= 2'd0;
      r_pass_cnt <= '0;
      r_settle   <= '0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
      r_ff_ab    <= 2'd0;
      r_ff_vec   <= 7'd0;
      r_ff_vld   <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
          if (w_launch) begin
            r_err      <= '0;
            r_pass     <= 1'b0;
            r_idx      <= 2'd0;
            r_pass_cnt <= '0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
            r_ff_ab    <= 2'd0;
            r_ff_vec   <= 7'd0;
            r_ff_vld   <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          r_a      <= r_idx[1];
          r_b      <= r_idx[0];
          r_settle <= c_SETTLE_LOAD;
        end
        SETTLE: begin
          if (!w_settle_end) r_settle <= r_settle - 1'b1;
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_err != c_ERR_MAX) r_err <= r_err + 1'b1;
`ifdef GATE_SEQ_FIRST_FAIL_EN
            if (!r_ff_vld) begin
              r_ff_ab  <= {r_a, r_b};
              r_ff_vec <= dut_y;
              r_ff_vld <= 1'b1;
            end
`endif
          end
          if (!w_last_vec) begin
            r_idx <= r_idx + 2'd1;
          end else if (!w_last_pass) begin
            r_idx      <= 2'd0;
            r_pass_cnt <= r_pass_cnt + 1'b1;
          end
        end
        DONE: begin
          // r_err already includes the final CHECK update here.
          r_pass <= (r_err == '0);
          r_a    <= 1'b0;
          r_b    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign busy    = w_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err;

`ifdef GATE_SEQ_FIRST_FAIL_EN
  assign first_fail_ab  = r_ff_ab;
  assign first_fail_vec = r_ff_vec;
  assign first_fail_vld = r_ff_vld;
`endif

endmodule

`default_nettype wire
